// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer: fetches 9-bit instructions, drives a clocked ALU,
// writes back its registered result and resolves overflow-conditioned branches.
module alu_sequencer #(
    parameter int PC_W  = 8,
    parameter int NREGS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    input  logic [8:0]      imem_data,
    output logic [5:0]      alu_opcode,
    output logic [7:0]      alu_in1,
    output logic [7:0]      alu_in2,
    input  logic [7:0]      alu_result,
    input  logic            alu_overflow,
    output logic            busy,
    output logic            done,
    input  logic [2:0]      dbg_sel,
    output logic [7:0]      dbg_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_regs [NREGS];
    logic            r_flag;
    logic [5:0]      r_exop;
    logic [2:0]      r_exrs;
    logic            r_busy;
    logic            r_done;

    logic [5:0]      w_opc;
    logic [2:0]      w_rs;
    logic            w_is_br;
    logic            w_is_halt;
    logic            w_taken;
    logic [PC_W-1:0] w_off;
    logic [PC_W-1:0] w_pc_inc;
    logic [2:0]      w_rd_sel;
    logic            w_wb_r0;
    logic            w_wb_rs;
    logic            w_upd_flag;

    assign w_opc     = imem_data[8:3];
    assign w_rs      = imem_data[2:0];
    assign w_is_br   = (imem_data[8:6] == 3'b111);
    assign w_is_halt = (w_opc == 6'b110111);
    assign w_taken   = (r_flag == imem_data[5]);
    assign w_off     = {{(PC_W-5){imem_data[4]}}, imem_data[4:0]};
    assign w_pc_inc  = r_pc + PC_W'(1);

    // ROM data is only valid during DECODE, so the ALU issue is driven from it directly
    assign w_rd_sel   = (r_state == S_DECODE) ? w_rs : r_exrs;
    assign alu_opcode = (r_state == S_DECODE && !w_is_br && !w_is_halt)
                        ? w_opc : 6'd0;
    assign alu_in1    = r_regs[0];
    assign alu_in2    = r_regs[w_rd_sel];
    assign imem_addr  = r_pc;
    assign busy       = r_busy;
    assign done       = r_done;
    assign dbg_data   = r_regs[dbg_sel];

    always_comb begin
        w_wb_r0    = 1'b0;
        w_wb_rs    = 1'b0;
        w_upd_flag = 1'b0;
        casez (r_exop)
            6'b010???: begin
                w_wb_r0    = 1'b1;
                w_upd_flag = 1'b1;
            end
            6'b101???: w_wb_r0 = 1'b1;
            6'b011???: w_upd_flag = 1'b1;
            6'b100???: w_upd_flag = 1'b1;
            6'b110000: begin
                w_wb_rs    = 1'b1;
                w_upd_flag = 1'b1;
            end
            6'b110001: w_wb_rs = 1'b1;
            6'b110010: w_wb_rs = 1'b1;
            6'b110101: w_wb_rs = 1'b1;
            6'b110011: w_upd_flag = 1'b1;
            6'b110100: w_upd_flag = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_flag  <= 1'b0;
            r_exop  <= 6'd0;
            r_exrs  <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= 8'd0;
            end
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_pc    <= '0;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    if (w_is_br) begin
                        r_pc    <= w_taken ? (r_pc + w_off) : w_pc_inc;
                        r_state <= S_FETCH;
                    end else if (w_is_halt) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_exop  <= w_opc;
                        r_exrs  <= w_rs;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // rs==0 with a reg[rs] writeback lands on r0 by construction
                    if (w_wb_r0) begin
                        r_regs[0] <= alu_result;
                    end else if (w_wb_rs) begin
                        r_regs[r_exrs] <= alu_result;
                    end
                    if (w_upd_flag) begin
                        r_flag <= alu_overflow;
                    end
                    r_pc    <= w_pc_inc;
                    r_state <= S_FETCH;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ROM and clocked ALU around the DUT,
// table-driven single-instruction programs plus multi-cycle sequences.
module tb_alu_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] imem_addr;
    logic [8:0] imem_data;
    logic [5:0] alu_opcode;
    logic [7:0] alu_in1;
    logic [7:0] alu_in2;
    logic [7:0] alu_result;
    logic       alu_overflow;
    logic       busy;
    logic       done;
    logic [2:0] dbg_sel;
    logic [7:0] dbg_data;

    logic [8:0] rom [256];
    int checks;
    int failures;
    int incr_cnt;

    typedef struct {
        logic [8:0] inst;
        logic [2:0] sel;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] val;
    } exp_t;

    vec_t tbl [12];
    exp_t sbq [$];

    alu_sequencer #(.PC_W(8), .NREGS(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .alu_opcode(alu_opcode),
        .alu_in1(alu_in1),
        .alu_in2(alu_in2),
        .alu_result(alu_result),
        .alu_overflow(alu_overflow),
        .busy(busy),
        .done(done),
        .dbg_sel(dbg_sel),
        .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= rom[imem_addr];

    // Reference ALU: registered result/overflow, NOP leaves state alone
    initial begin
        alu_result   = 8'd0;
        alu_overflow = 1'b0;
        imem_data    = 9'd0;
    end
    always @(posedge clk) begin
        casez (alu_opcode)
            6'b000000: ;
            6'b010???: {alu_overflow, alu_result} <= {1'b0, alu_in1} + {1'b0, alu_in2};
            6'b101???: alu_result <= (alu_in1 > alu_in2) ? alu_in1 - alu_in2 : alu_in2 - alu_in1;
            6'b011???: begin
                alu_result   <= 8'hA5;
                alu_overflow <= (alu_in1 == alu_in2);
            end
            6'b100???: begin
                alu_result   <= 8'hA5;
                alu_overflow <= (alu_in1 < alu_in2);
            end
            6'b110000: begin
                alu_result   <= alu_in2 << 1;
                alu_overflow <= alu_in2[7];
            end
            6'b110001: alu_result <= alu_in2 >> 1;
            6'b110010: alu_result <= alu_in2 + 8'd1;
            6'b110011: begin
                alu_result   <= 8'hA5;
                alu_overflow <= alu_in2[0];
            end
            6'b110100: begin
                alu_result   <= 8'hA5;
                alu_overflow <= (alu_in2 == 8'd0);
            end
            6'b110101: alu_result <= 8'd0;
            default:   alu_result <= 8'hA5;
        endcase
    end

    always @(negedge clk) if (alu_opcode == 6'h32) incr_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 2000) begin
            step();
            cyc++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic rd(input logic [2:0] s, output logic [7:0] v);
        dbg_sel = s;
        #1;
        v = dbg_data;
    endtask

    task automatic sb_drain(input string tag);
        exp_t e;
        logic [7:0] v;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            rd(e.sel, v);
            chk($sformatf("%s_r%0d", tag, e.sel), 32'(v), 32'(e.val));
        end
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    task automatic fill_rom(input logic [8:0] w);
        for (int i = 0; i < 256; i++) rom[i] = w;
    endtask

    task automatic load_prog1();
        fill_rom(9'h1B8);
        rom[0] = 9'h191;
        rom[1] = 9'h191;
        rom[2] = 9'h191;
        rom[3] = 9'h081;
        rom[4] = 9'h1B8;
    endtask

    initial begin
        int cyc;
        int c2;
        logic [7:0] v;
        logic [7:0] prev;
        bit wrapped;
        bit wrap_busy;

        checks   = 0;
        failures = 0;
        incr_cnt = 0;
        start    = 1'b0;
        dbg_sel  = 3'd0;
        rst_n    = 1'b0;
        fill_rom(9'h1B8);

        tbl[0]  = '{9'h192, 3'd2, 8'd1};
        tbl[1]  = '{9'h192, 3'd2, 8'd2};
        tbl[2]  = '{9'h182, 3'd2, 8'd4};
        tbl[3]  = '{9'h18A, 3'd2, 8'd2};
        tbl[4]  = '{9'h082, 3'd0, 8'd2};
        tbl[5]  = '{9'h193, 3'd3, 8'd1};
        tbl[6]  = '{9'h143, 3'd0, 8'd1};
        tbl[7]  = '{9'h1AA, 3'd2, 8'd0};
        tbl[8]  = '{9'h190, 3'd0, 8'd2};
        tbl[9]  = '{9'h0C3, 3'd0, 8'd2};
        tbl[10] = '{9'h043, 3'd3, 8'd1};
        tbl[11] = '{9'h1B3, 3'd3, 8'd1};

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_opcode", 32'(alu_opcode), 32'd0);
        chk("rst_pc", 32'(imem_addr), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            chk($sformatf("rst_r%0d", i), 32'(v), 32'd0);
        end

        // Single-instruction programs, cumulative register state
        for (int i = 0; i < 12; i++) begin
            fill_rom(9'h1B8);
            rom[0] = tbl[i].inst;
            sbq.push_back('{tbl[i].sel, tbl[i].exp});
            pulse_start();
            wait_done(cyc);
            chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'd5);
            sb_drain($sformatf("vec%0d", i));
        end

        do_reset();
        load_prog1();
        incr_cnt = 0;
        pulse_start();
        wait_done(cyc);
        chk("prog1_cycles", 32'(cyc), 32'd14);
        chk("prog1_incr_cycles", 32'(incr_cnt), 32'd3);
        sbq.push_back('{3'd1, 8'd3});
        sbq.push_back('{3'd0, 8'd3});
        sb_drain("prog1");

        // Restart from DONE with a stray start while busy
        pulse_start();
        chk("restart_done_low", 32'(done), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        repeat (4) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(c2);
        chk("restart_cycles", 32'(c2 + 5), 32'd14);
        sbq.push_back('{3'd1, 8'd6});
        sbq.push_back('{3'd0, 8'd9});
        sb_drain("restart");

        fill_rom(9'h1B8);
        rom[0] = 9'h191;
        pulse_start();
        step();
        chk("midexec_decode_op", 32'(alu_opcode), 32'h32);
        step();
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("midexec_busy", 32'(busy), 32'd0);
        chk("midexec_pc", 32'(imem_addr), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            chk($sformatf("midexec_r%0d", i), 32'(v), 32'd0);
        end

        fill_rom(9'h1B8);
        for (int i = 0; i < 100; i++) rom[i] = 9'h191;
        rom[100] = 9'h081;
        rom[101] = 9'h081;
        rom[102] = 9'h081;
        rom[103] = 9'h1E2;
        rom[104] = 9'h192;
        rom[105] = 9'h1B8;
        pulse_start();
        wait_done(cyc);
        chk("ovf_halt_pc", 32'(imem_addr), 32'd105);
        sbq.push_back('{3'd0, 8'd44});
        sbq.push_back('{3'd1, 8'd100});
        sbq.push_back('{3'd2, 8'd0});
        sb_drain("ovf");

        do_reset();
        fill_rom(9'h1B8);
        rom[0] = 9'h1A2;
        rom[1] = 9'h1FE;
        pulse_start();
        wait_done(cyc);
        chk("bwd_halt_pc", 32'(imem_addr), 32'd255);
        chk("bwd_cycles", 32'(cyc), 32'd7);

        fill_rom(9'h1B8);
        rom[0] = 9'h1A2;
        rom[1] = 9'h1C5;
        rom[6] = 9'h193;
        pulse_start();
        wait_done(cyc);
        chk("bno_halt_pc", 32'(imem_addr), 32'd2);
        sbq.push_back('{3'd3, 8'd0});
        sb_drain("bno");

        fill_rom(9'h000);
        pulse_start();
        wrapped   = 1'b0;
        wrap_busy = 1'b0;
        prev      = imem_addr;
        for (int i = 0; i < 900 && !wrapped; i++) begin
            step();
            if (prev == 8'd255 && imem_addr == 8'd0) begin
                wrapped   = 1'b1;
                wrap_busy = busy;
            end
            prev = imem_addr;
        end
        chk("wrap_seen", 32'(wrapped), 32'd1);
        chk("wrap_busy", 32'(wrap_busy), 32'd1);
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
